// File: rtl/bus_pkg.sv
// bus_pkg: shared definitions for the bus_fabric interconnect.
//   - bus_state_e : transaction FSM states (IDLE, ACCESS, WAIT, RESP)
//   - CAUSE_*     : fault cause encodings reported on fault_cause
//   - wait_slice  : extracts one slave's 4-bit wait count from a packed table
//   - idx_width   : width of a slave index for a given slave count
package bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RESP   = 2'd3
    } bus_state_e;

    localparam logic CAUSE_UNMAPPED = 1'b0;
    localparam logic CAUSE_TIMEOUT  = 1'b1;

    // Upper bound on the number of windows; wait tables are widened to this
    // size so the slice helper has a fixed signature.
    localparam int MAX_SLAVES = 16;

    function automatic logic [3:0] wait_slice(input logic [MAX_SLAVES*4-1:0] waits,
                                              input logic [3:0]              idx);
        return waits[{idx, 2'b00} +: 4];
    endfunction

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bus_addr_match.sv
// bus_addr_match: combinational priority address decoder.
// A window i hits when (addr & mask_i) == base_i; the lowest hitting index
// wins. The offset is the address with the window's mask bits removed.
// Ports:
//   addr   in  ADDR_W  address to decode
//   hit    out 1       some window matched
//   idx    out IDX_W   index of the winning window (0 on miss)
//   offset out ADDR_W  addr & ~mask of the winning window (0 on miss)
module bus_addr_match
    import bus_pkg::*;
#(
    parameter int                           ADDR_W     = 16,
    parameter int                           NUM_SLAVES = 4,
    parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_BASE = {16'h2000, 16'h1080, 16'h1000, 16'h0000},
    parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_MASK = {16'hF000, 16'hFFFF, 16'hFF80, 16'hF800},
    parameter int                           IDX_W      = idx_width(NUM_SLAVES)
) (
    input  logic [ADDR_W-1:0] addr,
    output logic              hit,
    output logic [IDX_W-1:0]  idx,
    output logic [ADDR_W-1:0] offset
);

    logic [NUM_SLAVES-1:0] hit_vec;
    logic [ADDR_W-1:0]     mask_arr [NUM_SLAVES];

    generate
        for (genvar gi = 0; gi < NUM_SLAVES; gi++) begin : g_win
            assign mask_arr[gi] = SLAVE_MASK[gi*ADDR_W +: ADDR_W];
            assign hit_vec[gi]  = ((addr & mask_arr[gi]) == SLAVE_BASE[gi*ADDR_W +: ADDR_W]);
        end
    endgenerate

    // Scan from the highest index down so the lowest hitting index is the
    // last assignment and therefore wins.
    always_comb begin
        hit    = |hit_vec;
        idx    = '0;
        offset = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if (hit_vec[i]) begin
                idx    = IDX_W'(i);
                offset = addr & ~mask_arr[i];
            end
        end
    end

endmodule

// File: rtl/bus_fabric.sv
// bus_fabric: request/ready interconnect from the CPU data port to
// NUM_SLAVES address windows, with per-slave wait states, slave ready,
// timeout and a sticky fault record.
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   m_address/m_din         master address / write data, held until m_ready
//   m_w_en/m_r_en           master write / read request (both => write)
//   m_dout/m_ready/m_fault  one-cycle response: data, completion, failure
//   s_sel                   one-hot select, held ACCESS through WAIT
//   s_w_en/s_r_en           one-cycle write / read strobe
//   s_offset/s_din          window-relative offset / write data to slaves
//   s_dout/s_ready          packed slave read data / per-slave ready
//   fault_valid/addr/cause/write  sticky record of the first uncleared fault
//   fault_clr               clears fault_valid
module bus_fabric
    import bus_pkg::*;
#(
    parameter int                           ADDR_W     = 16,
    parameter int                           DATA_W     = 8,
    parameter int                           NUM_SLAVES = 4,
    parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_BASE = {16'h2000, 16'h1080, 16'h1000, 16'h0000},
    parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_MASK = {16'hF000, 16'hFFFF, 16'hFF80, 16'hF800},
    parameter logic [NUM_SLAVES*4-1:0]      SLAVE_WAIT = {4'd1, 4'd0, 4'd0, 4'd0},
    parameter int                           TIMEOUT    = 32
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [ADDR_W-1:0]            m_address,
    input  logic [DATA_W-1:0]            m_din,
    input  logic                         m_w_en,
    input  logic                         m_r_en,
    output logic [DATA_W-1:0]            m_dout,
    output logic                         m_ready,
    output logic                         m_fault,
    output logic [NUM_SLAVES-1:0]        s_sel,
    output logic [NUM_SLAVES-1:0]        s_w_en,
    output logic [NUM_SLAVES-1:0]        s_r_en,
    output logic [ADDR_W-1:0]            s_offset,
    output logic [DATA_W-1:0]            s_din,
    input  logic [NUM_SLAVES*DATA_W-1:0] s_dout,
    input  logic [NUM_SLAVES-1:0]        s_ready,
    output logic                         fault_valid,
    output logic [ADDR_W-1:0]            fault_addr,
    output logic                         fault_cause,
    output logic                         fault_write,
    input  logic                         fault_clr
);

    localparam int IDX_W = idx_width(NUM_SLAVES);
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [MAX_SLAVES*4-1:0] WAIT_ALL = (MAX_SLAVES*4)'(SLAVE_WAIT);

    bus_state_e          state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   din_q, din_d;
    logic                write_q, write_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [ADDR_W-1:0]   offset_q, offset_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   dout_q, dout_d;
    logic                resp_fault_q, resp_fault_d;

    logic                fault_valid_q, fault_valid_d;
    logic [ADDR_W-1:0]   fault_addr_q, fault_addr_d;
    logic                fault_cause_q, fault_cause_d;
    logic                fault_write_q, fault_write_d;

    // Fault event raised by the FSM in the cycle the faulting response is
    // decided; the capture logic below turns it into the sticky record.
    logic                fault_evt;
    logic [ADDR_W-1:0]   fault_evt_addr;
    logic                fault_evt_cause;
    logic                fault_evt_write;

    logic                match_hit;
    logic [IDX_W-1:0]    match_idx;
    logic [ADDR_W-1:0]   match_offset;

    logic [NUM_SLAVES-1:0] sel_oh;
    logic [DATA_W-1:0]     dout_sel;
    logic                  ready_sel;
    logic [3:0]            wait_sel;

    bus_addr_match #(
        .ADDR_W     (ADDR_W),
        .NUM_SLAVES (NUM_SLAVES),
        .SLAVE_BASE (SLAVE_BASE),
        .SLAVE_MASK (SLAVE_MASK),
        .IDX_W      (IDX_W)
    ) u_match (
        .addr   (m_address),
        .hit    (match_hit),
        .idx    (match_idx),
        .offset (match_offset)
    );

    generate
        for (genvar gi = 0; gi < NUM_SLAVES; gi++) begin : g_sel
            assign sel_oh[gi] = (idx_q == IDX_W'(gi));
        end
    endgenerate

    // One-hot AND-OR selection of the active slave's data and ready.
    always_comb begin
        dout_sel  = '0;
        ready_sel = 1'b0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (sel_oh[i]) begin
                dout_sel  = dout_sel | s_dout[i*DATA_W +: DATA_W];
                ready_sel = ready_sel | s_ready[i];
            end
        end
        wait_sel = wait_slice(WAIT_ALL, 4'(idx_q));
    end

    always_comb begin
        state_d         = state_q;
        addr_d          = addr_q;
        din_d           = din_q;
        write_d         = write_q;
        idx_d           = idx_q;
        offset_d        = offset_q;
        cnt_d           = cnt_q;
        dout_d          = dout_q;
        resp_fault_d    = resp_fault_q;
        fault_evt       = 1'b0;
        fault_evt_addr  = addr_q;
        fault_evt_cause = CAUSE_UNMAPPED;
        fault_evt_write = write_q;

        unique case (state_q)
            ST_IDLE: begin
                if (m_w_en || m_r_en) begin
                    addr_d  = m_address;
                    din_d   = m_din;
                    write_d = m_w_en;
                    cnt_d   = '0;
                    if (match_hit) begin
                        idx_d        = match_idx;
                        offset_d     = match_offset;
                        resp_fault_d = 1'b0;
                        state_d      = ST_ACCESS;
                    end else begin
                        // Unmapped: answer immediately, never touch a slave.
                        offset_d        = '0;
                        dout_d          = '0;
                        resp_fault_d    = 1'b1;
                        fault_evt       = 1'b1;
                        fault_evt_addr  = m_address;
                        fault_evt_cause = CAUSE_UNMAPPED;
                        fault_evt_write = m_w_en;
                        state_d         = ST_RESP;
                    end
                end
            end
            ST_ACCESS: begin
                cnt_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // Completion is tested before timeout so a slave that becomes
                // ready on the final counted cycle still completes cleanly.
                if ((int'(cnt_q) >= int'(wait_sel)) && ready_sel) begin
                    dout_d       = write_q ? '0 : dout_sel;
                    resp_fault_d = 1'b0;
                    state_d      = ST_RESP;
                end else if (cnt_q == CNT_W'(TIMEOUT)) begin
                    dout_d          = '0;
                    resp_fault_d    = 1'b1;
                    fault_evt       = 1'b1;
                    fault_evt_cause = CAUSE_TIMEOUT;
                    state_d         = ST_RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Sticky fault record: a clear in the same cycle as a new fault lets the
    // new fault overwrite the record, keeping valid set.
    always_comb begin
        fault_valid_d = fault_valid_q;
        fault_addr_d  = fault_addr_q;
        fault_cause_d = fault_cause_q;
        fault_write_d = fault_write_q;
        if (fault_clr) begin
            fault_valid_d = 1'b0;
        end
        if (fault_evt && (!fault_valid_q || fault_clr)) begin
            fault_valid_d = 1'b1;
            fault_addr_d  = fault_evt_addr;
            fault_cause_d = fault_evt_cause;
            fault_write_d = fault_evt_write;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            addr_q        <= '0;
            din_q         <= '0;
            write_q       <= 1'b0;
            idx_q         <= '0;
            offset_q      <= '0;
            cnt_q         <= '0;
            dout_q        <= '0;
            resp_fault_q  <= 1'b0;
            fault_valid_q <= 1'b0;
            fault_addr_q  <= '0;
            fault_cause_q <= 1'b0;
            fault_write_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            din_q         <= din_d;
            write_q       <= write_d;
            idx_q         <= idx_d;
            offset_q      <= offset_d;
            cnt_q         <= cnt_d;
            dout_q        <= dout_d;
            resp_fault_q  <= resp_fault_d;
            fault_valid_q <= fault_valid_d;
            fault_addr_q  <= fault_addr_d;
            fault_cause_q <= fault_cause_d;
            fault_write_q <= fault_write_d;
        end
    end

    // Outputs decode from registered state so reset forces them low at once.
    assign m_ready     = (state_q == ST_RESP);
    assign m_dout      = m_ready ? dout_q : '0;
    assign m_fault     = m_ready & resp_fault_q;
    assign s_sel       = ((state_q == ST_ACCESS) || (state_q == ST_WAIT)) ? sel_oh : '0;
    assign s_w_en      = ((state_q == ST_ACCESS) && write_q)  ? sel_oh : '0;
    assign s_r_en      = ((state_q == ST_ACCESS) && !write_q) ? sel_oh : '0;
    assign s_offset    = offset_q;
    assign s_din       = din_q;
    assign fault_valid = fault_valid_q;
    assign fault_addr  = fault_addr_q;
    assign fault_cause = fault_cause_q;
    assign fault_write = fault_write_q;

endmodule

// File: tb/tb_bus_fabric.sv
// Testbench for bus_fabric: directed scenarios followed by randomized
// transactions, each checked against a transaction-level reference model.
module tb_bus_fabric;

    localparam int TB_TIMEOUT = 32;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] m_address;
    logic [7:0]  m_din;
    logic        m_w_en, m_r_en;
    logic [7:0]  m_dout;
    logic        m_ready, m_fault;
    logic [3:0]  s_sel, s_w_en, s_r_en;
    logic [15:0] s_offset;
    logic [7:0]  s_din;
    logic [31:0] s_dout;
    logic [3:0]  s_ready;
    logic        fault_valid;
    logic [15:0] fault_addr;
    logic        fault_cause, fault_write, fault_clr;

    int compared   = 0;
    int mismatched = 0;

    // Window table: slot 0 is the least significant entry of the packed
    // parameters, so it is listed first here.
    logic [15:0] base_t [4] = '{16'h0000, 16'h1000, 16'h1080, 16'h2000};
    logic [15:0] mask_t [4] = '{16'hF800, 16'hFF80, 16'hFFFF, 16'hF000};
    int          wait_t [4] = '{0, 0, 0, 1};

    // Reference fault record.
    logic        mdl_fv;
    logic [15:0] mdl_fa;
    logic        mdl_fc, mdl_fw;

    bus_fabric #(.TIMEOUT(TB_TIMEOUT)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .m_address   (m_address),
        .m_din       (m_din),
        .m_w_en      (m_w_en),
        .m_r_en      (m_r_en),
        .m_dout      (m_dout),
        .m_ready     (m_ready),
        .m_fault     (m_fault),
        .s_sel       (s_sel),
        .s_w_en      (s_w_en),
        .s_r_en      (s_r_en),
        .s_offset    (s_offset),
        .s_din       (s_din),
        .s_dout      (s_dout),
        .s_ready     (s_ready),
        .fault_valid (fault_valid),
        .fault_addr  (fault_addr),
        .fault_cause (fault_cause),
        .fault_write (fault_write),
        .fault_clr   (fault_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int decode(input logic [15:0] a);
        for (int i = 0; i < 4; i++) begin
            if ((a & mask_t[i]) == base_t[i]) return i;
        end
        return -1;
    endfunction

    // One master transaction. rdelay = number of leading WAIT cycles with the
    // target's s_ready low; dval >= 0 forces every slave's read data.
    task automatic run_txn(input logic [15:0] addr, input logic wr, input logic rd,
                           input logic [7:0] wdata, input int rdelay,
                           input logic clr, input int dval);
        int          slot;
        int          k;
        int          exp_lat;
        logic [7:0]  exp_dout;
        logic        exp_fault;
        logic        exp_cause;
        logic [3:0]  oh;
        int          lat;
        logic        done;
        logic [7:0]  got_dout;
        logic        got_fault;
        int          strobes;
        int          st_cyc;
        logic [3:0]  st_w, st_r, st_sel, sel_at_rdy;
        logic [15:0] st_off;
        logic [7:0]  st_din;

        for (int i = 0; i < 4; i++)
            s_dout[i*8 +: 8] = (dval >= 0) ? 8'(dval) : 8'($urandom);

        slot      = decode(addr);
        oh        = (slot >= 0) ? (4'b0001 << slot) : 4'b0000;
        exp_cause = 1'b0;
        if (slot < 0) begin
            exp_lat   = 1;
            exp_fault = 1'b1;
            exp_dout  = 8'h00;
        end else begin
            k = (wait_t[slot] > rdelay) ? wait_t[slot] : rdelay;
            if (k > TB_TIMEOUT) begin
                k         = TB_TIMEOUT;
                exp_fault = 1'b1;
                exp_cause = 1'b1;
                exp_dout  = 8'h00;
            end else begin
                exp_fault = 1'b0;
                exp_dout  = wr ? 8'h00 : s_dout[slot*8 +: 8];
            end
            exp_lat = k + 3;
        end
        if (clr) mdl_fv = 1'b0;
        if (exp_fault && !mdl_fv) begin
            mdl_fv = 1'b1;
            mdl_fa = addr;
            mdl_fc = exp_cause;
            mdl_fw = wr;
        end

        @(negedge clk);
        m_address = addr;
        m_din     = wdata;
        m_w_en    = wr;
        m_r_en    = rd;
        fault_clr = clr;
        s_ready   = 4'hF;
        done = 1'b0; lat = 0; strobes = 0; st_cyc = 0;
        got_dout = '0; got_fault = 1'b0; sel_at_rdy = '0;
        st_w = '0; st_r = '0; st_sel = '0; st_off = '0; st_din = '0;

        for (int c = 1; c <= 100 && !done; c++) begin
            @(posedge clk);
            #1;
            fault_clr = 1'b0;
            s_ready   = 4'hF;
            if (slot >= 0 && (c - 2) < rdelay) s_ready[slot] = 1'b0;
            if (s_w_en != 4'b0 || s_r_en != 4'b0) begin
                strobes++;
                if (strobes == 1) begin
                    st_cyc = c; st_w = s_w_en; st_r = s_r_en; st_sel = s_sel;
                    st_off = s_offset; st_din = s_din;
                end
            end
            if (m_ready) begin
                done       = 1'b1;
                lat        = c;
                got_dout   = m_dout;
                got_fault  = m_fault;
                sel_at_rdy = s_sel;
                m_w_en     = 1'b0;
                m_r_en     = 1'b0;
            end
        end
        m_w_en  = 1'b0;
        m_r_en  = 1'b0;
        s_ready = 4'hF;

        chk("m_ready_seen", 32'(done), 32'd1);
        chk("latency", 32'(lat), 32'(exp_lat));
        chk("m_dout", 32'(got_dout), 32'(exp_dout));
        chk("m_fault", 32'(got_fault), 32'(exp_fault));
        chk("strobe_count", 32'(strobes), (slot >= 0) ? 32'd1 : 32'd0);
        chk("sel_at_ready", 32'(sel_at_rdy), 32'd0);
        if (slot >= 0) begin
            chk("strobe_cycle", 32'(st_cyc), 32'd1);
            chk("s_sel", 32'(st_sel), 32'(oh));
            chk("s_w_en", 32'(st_w), wr ? 32'(oh) : 32'd0);
            chk("s_r_en", 32'(st_r), wr ? 32'd0 : 32'(oh));
            chk("s_offset", 32'(st_off), 32'(addr & ~mask_t[slot]));
            if (wr) chk("s_din", 32'(st_din), 32'(wdata));
        end
        chk("fault_valid", 32'(fault_valid), 32'(mdl_fv));
        if (mdl_fv) begin
            chk("fault_addr", 32'(fault_addr), 32'(mdl_fa));
            chk("fault_cause", 32'(fault_cause), 32'(mdl_fc));
            chk("fault_write", 32'(fault_write), 32'(mdl_fw));
        end
        @(posedge clk);
        #1;
        chk("m_ready_one_cycle", 32'(m_ready), 32'd0);
        $display("txn %s addr=%h slot=%0d rdelay=%0d clr=%0d lat=%0d dout=%h fault=%0d fv=%0d fa=%h",
                 wr ? "WR" : "RD", addr, slot, rdelay, clr, lat, got_dout, got_fault,
                 fault_valid, fault_addr);
    endtask

    initial begin
        rst_n     = 1'b0;
        m_address = '0;
        m_din     = '0;
        m_w_en    = 1'b0;
        m_r_en    = 1'b0;
        fault_clr = 1'b0;
        s_dout    = '0;
        s_ready   = 4'hF;
        mdl_fv    = 1'b0;
        mdl_fa    = '0;
        mdl_fc    = 1'b0;
        mdl_fw    = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk("reset_m_ready", 32'(m_ready), 32'd0);
        chk("reset_s_sel", 32'(s_sel), 32'd0);
        chk("reset_fault_valid", 32'(fault_valid), 32'd0);
        chk("reset_s_offset", 32'(s_offset), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed scenarios.
        run_txn(16'h0005, 1'b0, 1'b1, 8'h00, 0, 1'b0, 8'hA5);
        run_txn(16'h2010, 1'b1, 1'b0, 8'h3C, 0, 1'b0, -1);
        run_txn(16'h0900, 1'b0, 1'b1, 8'h00, 0, 1'b0, -1);
        run_txn(16'h1005, 1'b0, 1'b1, 8'h00, 1000, 1'b1, -1);
        run_txn(16'h0900, 1'b0, 1'b1, 8'h00, 0, 1'b0, -1);
        run_txn(16'h3000, 1'b1, 1'b0, 8'h55, 0, 1'b1, -1);
        run_txn(16'h1080, 1'b0, 1'b1, 8'h00, 3, 1'b0, -1);
        run_txn(16'h2FFF, 1'b1, 1'b1, 8'h9E, 0, 1'b1, -1);

        // Asynchronous reset in the middle of a WAIT.
        @(negedge clk);
        m_address = 16'h1005;
        m_r_en    = 1'b1;
        s_ready   = 4'hF;
        s_ready[decode(16'h1005)] = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("pre_reset_sel", 32'(s_sel), 32'(4'b0001 << decode(16'h1005)));
        rst_n = 1'b0;
        #1;
        chk("rst_m_ready", 32'(m_ready), 32'd0);
        chk("rst_m_fault", 32'(m_fault), 32'd0);
        chk("rst_m_dout", 32'(m_dout), 32'd0);
        chk("rst_s_sel", 32'(s_sel), 32'd0);
        chk("rst_s_strobes", 32'({s_w_en, s_r_en}), 32'd0);
        chk("rst_s_offset", 32'(s_offset), 32'd0);
        chk("rst_s_din", 32'(s_din), 32'd0);
        chk("rst_fault_rec", 32'({fault_valid, fault_cause, fault_write, fault_addr}), 32'd0);
        m_r_en  = 1'b0;
        s_ready = 4'hF;
        mdl_fv  = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset_fault_valid", 32'(fault_valid), 32'd0);
        run_txn(16'h1010, 1'b0, 1'b1, 8'h00, 0, 1'b0, -1);

        // Randomized traffic.
        for (int n = 0; n < 40; n++) begin
            logic [15:0] a;
            int          r;
            int          op;
            int          rd_dly;
            r = $urandom_range(0, 4);
            case (r)
                0:       a = {5'b00000, 11'($urandom)};
                1:       a = 16'h1000 | 16'($urandom_range(0, 127));
                2:       a = 16'h1080;
                3:       a = 16'h2000 | 16'($urandom_range(0, 4095));
                default: a = 16'($urandom);
            endcase
            op     = $urandom_range(0, 2);
            rd_dly = ($urandom_range(0, 9) == 0) ? 40 : $urandom_range(0, 3);
            run_txn(a, (op != 0), (op != 1), 8'($urandom), rd_dly,
                    ($urandom_range(0, 3) == 0), -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
